// File: rtl/neuro_wb_pkg.sv
// Shared types and address constants for the Neuromorphic_X1 Wishbone path.
// Also used by the wrapper address decode.
package neuro_wb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, ERRACK, RELEASE} arb_state_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

    localparam logic [31:0] NEURO_BASE = 32'h3000_0000;
    localparam logic [31:0] MPRJ_MASK  = 32'hFFFF_F000;

    function automatic logic in_neuro_region(input logic [31:0] adr);
        return (adr & MPRJ_MASK) == NEURO_BASE;
    endfunction

endpackage

// File: rtl/wb_rr_pick2.sv
// Combinational two-way round-robin picker.
// On contention the requester that was not granted last wins.
module wb_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = last ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/neuro_wb_arbiter.sv
// Two-requester round-robin Wishbone arbiter in front of the Neuromorphic_X1 macro.
// A watchdog turns a missing macro ack into an error-ack so the host never hangs.
module neuro_wb_arbiter
    import neuro_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o,
    output logic        timeout_flag_o,
    input  logic        timeout_clr_i
);

    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state, next_state;
    logic [1:0]       grant, pick, req;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;
    logic             timeout_flag;
    wb_req_t          req0, req1, sel_req, s_req;
    logic             ack;
    logic [31:0]      rdat;

    assign req0    = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
    assign req1    = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};
    assign req     = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
    assign sel_req = grant[1] ? req1 : req0;

    wb_rr_pick2 u_pick (
        .req   (req),
        .last  (last_grant),
        .grant (pick)
    );

    always_comb begin
        next_state = state;
        s_req      = '0;
        ack        = 1'b0;
        rdat       = '0;
        case (state)
            IDLE: if (|req) next_state = BUSY;
            BUSY: begin
                s_req = sel_req;
                ack   = s_ack_i & sel_req.cyc;
                rdat  = s_dat_i;
                // Abort first, then ack; an ack on the limit cycle beats the watchdog.
                if (!sel_req.cyc || s_ack_i) next_state = RELEASE;
                else if (cnt == CNT_LIM)     next_state = ERRACK;
            end
            ERRACK: begin
                ack        = 1'b1;
                rdat       = ERR_DATA;
                next_state = RELEASE;
            end
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            grant        <= '0;
            last_grant   <= 1'b1;
            cnt          <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (|req) begin
                    grant      <= pick;
                    last_grant <= pick[1];
                    cnt        <= '0;
                end
                BUSY: begin
                    if (next_state == RELEASE) grant <= '0;
                    if (cnt != CNT_LIM) cnt <= cnt + CNT_W'(1);
                end
                ERRACK:  grant <= '0;
                default: ;
            endcase
            // Set has priority over a coincident clear.
            if (state == ERRACK)    timeout_flag <= 1'b1;
            else if (timeout_clr_i) timeout_flag <= 1'b0;
        end
    end

    assign s_cyc_o        = s_req.cyc;
    assign s_stb_o        = s_req.stb;
    assign s_we_o         = s_req.we;
    assign s_sel_o        = s_req.sel;
    assign s_adr_o        = s_req.adr;
    assign s_dat_o        = s_req.dat;
    assign m0_ack_o       = ack & grant[0];
    assign m1_ack_o       = ack & grant[1];
    assign m0_dat_o       = grant[0] ? rdat : '0;
    assign m1_dat_o       = grant[1] ? rdat : '0;
    assign grant_o        = grant;
    assign timeout_flag_o = timeout_flag;

endmodule

// File: tb/tb_neuro_wb_arbiter.sv
// Directed bench for neuro_wb_arbiter: handshake, fairness, watchdog, abort and reset.
// A small macro model acks after a programmable latency.
module tb_neuro_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel, s_sel;
    logic [31:0] m0_adr, m0_wdat, m0_rdat, m1_adr, m1_wdat, m1_rdat;
    logic        m0_ack, m1_ack;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic [1:0]  grant;
    logic        tflag, tclr;

    always #5 clk = ~clk;

    neuro_wb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack),
        .grant_o(grant), .timeout_flag_o(tflag), .timeout_clr_i(tclr)
    );

    // Macro model: ack once the strobe has been seen for lat cycles.
    logic ack_en;
    int   lat;
    int   mcnt = 0;
    always @(posedge clk) mcnt <= (s_cyc && s_stb && !s_ack) ? mcnt + 1 : 0;
    assign s_ack = ack_en && s_cyc && s_stb && (mcnt == lat);

    int         n_chk = 0, n_pass = 0;
    int         cyc_n = 0, ack0_n = 0, ack1_n = 0, viol = 0;
    logic [1:0] gprev = 2'b00;
    logic [1:0] gq[$];
    int         tq[$];

    always @(negedge clk) begin
        cyc_n <= cyc_n + 1;
        if (m0_ack) ack0_n <= ack0_n + 1;
        if (m1_ack) ack1_n <= ack1_n + 1;
        if ((m0_ack && !grant[0]) || (m1_ack && !grant[1])) viol <= viol + 1;
        if (grant != 2'b00 && gprev == 2'b00) begin
            gq.push_back(grant);
            tq.push_back(cyc_n);
        end
        gprev <= grant;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m0_drive(input logic on, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m0_cyc = on; m0_stb = on; m0_we = we; m0_sel = 4'hF; m0_adr = adr; m0_wdat = dat;
    endtask

    task automatic m1_drive(input logic on, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m1_cyc = on; m1_stb = on; m1_we = we; m1_sel = 4'h3; m1_adr = adr; m1_wdat = dat;
    endtask

    int a0, a1;

    initial begin
        rst = 1'b1; tclr = 1'b0; ack_en = 1'b1; lat = 1; s_rdat = '0;
        m0_drive(0, 0, '0, '0);
        m1_drive(0, 0, '0, '0);
        tick(2);
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_grant", grant, 0);
        chk("rst_flag", tflag, 0);
        chk("rst_m0_dat", m0_rdat, 0);
        rst = 1'b0;
        tick();

        // 1: single host read, macro acks after 3 cycles
        s_rdat = 32'h1234_5678; lat = 3;
        m0_drive(1, 0, 32'h3000_0004, '0);
        #1 chk("t1_stb_pre", s_stb, 0);
        tick();
        chk("t1_stb", s_stb, 1);
        chk("t1_grant", grant, 2'b01);
        chk("t1_adr", s_adr, 32'h3000_0004);
        tick(3);
        chk("t1_ack", m0_ack, 1);
        chk("t1_dat", m0_rdat, 32'h1234_5678);
        chk("t1_m1_dat", m1_rdat, 0);
        tick();
        chk("t1_rel_grant", grant, 0);
        chk("t1_rel_ack", m0_ack, 0);
        chk("t1_rel_cyc", s_cyc, 0);
        m0_drive(0, 0, '0, '0);
        tick(2);
        chk("t1_ack_cnt", 32'(ack0_n), 1);

        // 2: both requesters held continuously, ack latency 1
        rst = 1'b1; tick(); rst = 1'b0; tick();
        gq.delete(); tq.delete();
        a0 = ack0_n; a1 = ack1_n; lat = 1;
        m0_drive(1, 0, 32'h3000_0008, '0);
        m1_drive(1, 1, 32'h3000_0010, 32'h0000_A5A5);
        tick(16);
        m0_drive(0, 0, '0, '0);
        m1_drive(0, 0, '0, '0);
        tick(2);
        chk("t2_ngrants", 32'(gq.size()), 4);
        if (gq.size() == 4) begin
            chk("t2_g0", gq[0], 2'b01);
            chk("t2_g1", gq[1], 2'b10);
            chk("t2_g2", gq[2], 2'b01);
            chk("t2_g3", gq[3], 2'b10);
            for (int k = 0; k < 3; k++) chk("t2_spacing", 32'(tq[k+1] - tq[k]), 4);
        end
        chk("t2_m0_acks", 32'(ack0_n - a0), 2);
        chk("t2_m1_acks", 32'(ack1_n - a1), 2);
        chk("t2_stray_ack", 32'(viol), 0);

        // 3: logger write with no macro ack -> error-ack, sticky flag, clear
        ack_en = 1'b0;
        m1_drive(1, 1, 32'h3000_0020, 32'hCAFE_0001);
        tick();
        chk("t3_grant", grant, 2'b10);
        chk("t3_we", s_we, 1);
        chk("t3_wdat", s_wdat, 32'hCAFE_0001);
        chk("t3_sel", s_sel, 4'h3);
        tick(7);
        chk("t3_busy8_cyc", s_cyc, 1);
        tick();
        chk("t3_err_cyc", s_cyc, 0);
        chk("t3_err_stb", s_stb, 0);
        chk("t3_err_ack", m1_ack, 1);
        chk("t3_err_dat", m1_rdat, 32'hDEAD_BEEF);
        chk("t3_flag_pre", tflag, 0);
        tick();
        chk("t3_flag", tflag, 1);
        chk("t3_rel_grant", grant, 0);
        chk("t3_rel_ack", m1_ack, 0);
        m1_drive(0, 0, '0, '0);
        tick(2);
        chk("t3_sticky", tflag, 1);
        tclr = 1'b1; tick(); tclr = 1'b0;
        chk("t3_clr", tflag, 0);
        ack_en = 1'b1;

        // 4: ack lands on the watchdog limit cycle
        lat = 7; s_rdat = 32'h0BAD_F00D;
        m0_drive(1, 0, 32'h3000_0008, '0);
        tick();
        tick(7);
        chk("t4_ack", m0_ack, 1);
        chk("t4_dat", m0_rdat, 32'h0BAD_F00D);
        tick();
        chk("t4_flag", tflag, 0);
        chk("t4_rel_grant", grant, 0);
        m0_drive(0, 0, '0, '0);
        tick(2);
        chk("t4_flag_after", tflag, 0);

        // 5: host aborts on BUSY cycle 2 while logger waits
        lat = 5; a0 = ack0_n;
        m0_drive(1, 0, 32'h3000_000C, '0);
        tick();
        chk("t5_grant0", grant, 2'b01);
        m1_drive(1, 0, 32'h3000_0030, '0);
        tick();
        m0_drive(0, 0, '0, '0);
        #1 chk("t5_abort_cyc", s_cyc, 0);
        chk("t5_abort_ack", m0_ack, 0);
        tick();
        chk("t5_rel_grant", grant, 0);
        tick(2);
        chk("t5_grant1", grant, 2'b10);
        for (int k = 0; k < 20; k++) begin
            if (m1_ack) break;
            tick();
        end
        chk("t5_m1_ack", m1_ack, 1);
        tick();
        m1_drive(0, 0, '0, '0);
        tick(2);
        chk("t5_no_m0_ack", 32'(ack0_n - a0), 0);

        // 6: reset mid-BUSY aborts, then host wins first contention
        ack_en = 1'b0; a0 = ack0_n;
        m0_drive(1, 0, 32'h3000_0040, '0);
        tick();
        chk("t6_grant0", grant, 2'b01);
        m1_drive(1, 0, 32'h3000_0044, '0);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_cyc", s_cyc, 0);
        chk("t6_rst_stb", s_stb, 0);
        chk("t6_rst_grant", grant, 0);
        rst = 1'b0;
        tick();
        chk("t6_first_grant", grant, 2'b01);
        m0_drive(0, 0, '0, '0);
        m1_drive(0, 0, '0, '0);
        tick(3);
        chk("t6_no_ack", 32'(ack0_n - a0), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
